calendar_sequencer: RTL and testbench

- BCD timekeeping controller that advances seconds, minutes, hours, date, month and year on a 1 Hz tick, one carry stage per clock cycle.
- Owns the single dateinfo instance and multiplexes it between two uses: the rollover sequence and validation of externally loaded times.
- Sits between the DS1302 read/write engine, which supplies load values, and the display/alarm logic, which consumes the fields and weekday.

---
 rtl/cal_pkg.sv | 45 ++++
 rtl/dateinfo.sv | 52 +++++
 rtl/calendar_sequencer.sv | 175 +++++++++++++++++
 tb/tb_calendar_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cal_pkg.sv
// Shared definitions for the calendar sequencer: FSM encoding, BCD limits and BCD helpers.
package cal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEC,
        ST_MIN,
        ST_HOUR,
        ST_DATE,
        ST_MONTH,
        ST_YEAR,
        ST_CHECK
    } state_t;

    localparam logic [7:0] BCD_MAX_SEC   = 8'h59;
    localparam logic [7:0] BCD_MAX_HOUR  = 8'h23;
    localparam logic [7:0] BCD_MAX_MONTH = 8'h12;
    localparam logic [7:0] BCD_MAX_YEAR  = 8'h99;

    // 2000-01-01 fell on a Saturday
    localparam logic [2:0] RST_DAY = 3'd6;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic bcd_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic [7:0] bcd_to_bin(input logic [7:0] v);
        return {4'd0, v[7:4]} * 8'd10 + {4'd0, v[3:0]};
    endfunction

    // Years are 2000..2099, so divisibility by 4 is the whole leap rule
    function automatic logic bcd_leap(input logic [7:0] y);
        logic [7:0] b;
        b = bcd_to_bin(y);
        return b[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/dateinfo.sv
// Combinational calendar facts for a BCD date in 2000..2099: month length, leap flag, weekday.
module dateinfo
    import cal_pkg::*;
(
    input  logic [7:0] year,
    input  logic [7:0] month,
    input  logic [7:0] date,
    output logic [7:0] days_in_month,
    output logic       leap_year,
    output logic [2:0] day
);

    logic [7:0]  yb;
    logic [7:0]  mb;
    logic [7:0]  db;
    logic [3:0]  t;
    logic [12:0] yf;
    logic [12:0] sum;

    always_comb begin
        yb        = bcd_to_bin(year);
        mb        = bcd_to_bin(month);
        db        = bcd_to_bin(date);
        leap_year = bcd_leap(year);

        case (month)
            8'h02:                      days_in_month = leap_year ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: days_in_month = 8'h30;
            default:                    days_in_month = 8'h31;
        endcase

        // Sakamoto weekday: Jan/Feb count as months of the previous year
        case (mb)
            8'd2:    t = 4'd3;
            8'd3:    t = 4'd2;
            8'd4:    t = 4'd5;
            8'd6:    t = 4'd3;
            8'd7:    t = 4'd5;
            8'd8:    t = 4'd1;
            8'd9:    t = 4'd4;
            8'd10:   t = 4'd6;
            8'd11:   t = 4'd2;
            8'd12:   t = 4'd4;
            default: t = 4'd0;
        endcase

        yf  = 13'd2000 + {5'd0, yb} - {12'd0, (mb < 8'd3)};
        sum = yf + yf / 13'd4 - yf / 13'd100 + yf / 13'd400 + {9'd0, t} + {5'd0, db};
        day = 3'(sum % 13'd7);
    end

endmodule

// File: rtl/calendar_sequencer.sv
// BCD timekeeping FSM: one carry stage per clock on each tick, plus validated time loads.
module calendar_sequencer
    import cal_pkg::*;
#(
    parameter logic [7:0] RST_YEAR  = 8'h00,
    parameter logic [7:0] RST_MONTH = 8'h01,
    parameter logic [7:0] RST_DATE  = 8'h01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       load_valid,
    input  logic [7:0] load_sec,
    input  logic [7:0] load_min,
    input  logic [7:0] load_hour,
    input  logic [7:0] load_date,
    input  logic [7:0] load_month,
    input  logic [7:0] load_year,
    output logic       load_ready,
    output logic       load_err,
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic [7:0] hour,
    output logic [7:0] date,
    output logic [7:0] month,
    output logic [7:0] year,
    output logic [2:0] day,
    output logic       leap_year,
    output logic       busy,
    output logic       new_day,
    output logic       tick_overrun
);

    state_t     state;
    logic       pending;
    logic [7:0] sh_sec, sh_min, sh_hour, sh_date, sh_month, sh_year;
    logic [7:0] di_year, di_month, di_date;
    logic [7:0] dim;
    logic       di_leap;
    logic [2:0] di_day;
    logic       load_ok;
    logic       carry_state;

    // The single dateinfo serves the live fields, except in CHECK where it judges the shadow copy
    always_comb begin
        di_year  = year;
        di_month = month;
        di_date  = date;
        if (state == ST_CHECK) begin
            di_year  = sh_year;
            di_month = sh_month;
            di_date  = sh_date;
        end
    end

    dateinfo u_dateinfo (
        .year          (di_year),
        .month         (di_month),
        .date          (di_date),
        .days_in_month (dim),
        .leap_year     (di_leap),
        .day           (di_day)
    );

    assign load_ok = bcd_ok(sh_sec) && bcd_ok(sh_min) && bcd_ok(sh_hour) &&
                     bcd_ok(sh_date) && bcd_ok(sh_month) && bcd_ok(sh_year) &&
                     (sh_sec <= BCD_MAX_SEC) && (sh_min <= BCD_MAX_SEC) &&
                     (sh_hour <= BCD_MAX_HOUR) &&
                     (sh_month >= 8'h01) && (sh_month <= BCD_MAX_MONTH) &&
                     (sh_date >= 8'h01) && (sh_date <= dim);

    assign carry_state = (state != ST_IDLE) && (state != ST_CHECK);
    assign load_ready  = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            pending      <= 1'b0;
            tick_overrun <= 1'b0;
            load_err     <= 1'b0;
            new_day      <= 1'b0;
            sec          <= 8'h00;
            min          <= 8'h00;
            hour         <= 8'h00;
            date         <= RST_DATE;
            month        <= RST_MONTH;
            year         <= RST_YEAR;
            day          <= RST_DAY;
            leap_year    <= bcd_leap(RST_YEAR);
            sh_sec       <= 8'h00;
            sh_min       <= 8'h00;
            sh_hour      <= 8'h00;
            sh_date      <= 8'h00;
            sh_month     <= 8'h00;
            sh_year      <= 8'h00;
        end else begin
            load_err <= 1'b0;
            new_day  <= (state == ST_DATE);

            // Held through CHECK so the shadow values never leak onto day/leap_year
            if (state != ST_CHECK) begin
                day       <= di_day;
                leap_year <= di_leap;
            end

            if (tick && carry_state) begin
                if (pending)
                    tick_overrun <= 1'b1;
                else
                    pending <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (load_valid) begin
                        sh_sec   <= load_sec;
                        sh_min   <= load_min;
                        sh_hour  <= load_hour;
                        sh_date  <= load_date;
                        sh_month <= load_month;
                        sh_year  <= load_year;
                        state    <= ST_CHECK;
                    end else if (tick || pending) begin
                        pending <= 1'b0;
                        if (tick && pending)
                            tick_overrun <= 1'b1;
                        state <= ST_SEC;
                    end
                end
                ST_SEC: begin
                    sec   <= (sec == BCD_MAX_SEC) ? 8'h00 : bcd_inc(sec);
                    state <= (sec == BCD_MAX_SEC) ? ST_MIN : ST_IDLE;
                end
                ST_MIN: begin
                    min   <= (min == BCD_MAX_SEC) ? 8'h00 : bcd_inc(min);
                    state <= (min == BCD_MAX_SEC) ? ST_HOUR : ST_IDLE;
                end
                ST_HOUR: begin
                    hour  <= (hour == BCD_MAX_HOUR) ? 8'h00 : bcd_inc(hour);
                    state <= (hour == BCD_MAX_HOUR) ? ST_DATE : ST_IDLE;
                end
                ST_DATE: begin
                    date  <= (date == dim) ? 8'h01 : bcd_inc(date);
                    state <= (date == dim) ? ST_MONTH : ST_IDLE;
                end
                ST_MONTH: begin
                    month <= (month == BCD_MAX_MONTH) ? 8'h01 : bcd_inc(month);
                    state <= (month == BCD_MAX_MONTH) ? ST_YEAR : ST_IDLE;
                end
                ST_YEAR: begin
                    year  <= (year == BCD_MAX_YEAR) ? 8'h00 : bcd_inc(year);
                    state <= ST_IDLE;
                end
                ST_CHECK: begin
                    if (load_ok) begin
                        sec          <= sh_sec;
                        min          <= sh_min;
                        hour         <= sh_hour;
                        date         <= sh_date;
                        month        <= sh_month;
                        year         <= sh_year;
                        pending      <= 1'b0;
                        tick_overrun <= 1'b0;
                    end else begin
                        load_err <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calendar_sequencer.sv
// Directed bench for calendar_sequencer with a queue of expected calendar snapshots.
module tb_calendar_sequencer;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       load_valid;
    logic [7:0] load_sec, load_min, load_hour, load_date, load_month, load_year;
    logic       load_ready, load_err;
    logic [7:0] sec, min, hour, date, month, year;
    logic [2:0] day;
    logic       leap_year, busy, new_day, tick_overrun;

    typedef struct {
        logic [7:0] year, month, date, hour, min, sec;
        logic [2:0] day;
        logic       leap;
    } exp_t;

    exp_t sb_q[$];
    int   n_asserts = 0;
    int   n_fail    = 0;

    calendar_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .load_valid   (load_valid),
        .load_sec     (load_sec),
        .load_min     (load_min),
        .load_hour    (load_hour),
        .load_date    (load_date),
        .load_month   (load_month),
        .load_year    (load_year),
        .load_ready   (load_ready),
        .load_err     (load_err),
        .sec          (sec),
        .min          (min),
        .hour         (hour),
        .date         (date),
        .month        (month),
        .year         (year),
        .day          (day),
        .leap_year    (leap_year),
        .busy         (busy),
        .new_day      (new_day),
        .tick_overrun (tick_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] y, mo, d, h, mi, s,
                            input logic [2:0] dw, input logic lp);
        exp_t e;
        e.year = y; e.month = mo; e.date = d;
        e.hour = h; e.min = mi;   e.sec = s;
        e.day  = dw; e.leap = lp;
        sb_q.push_back(e);
    endtask

    task automatic check_sb(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, "_year"},  year,      e.year);
        chk({tag, "_month"}, month,     e.month);
        chk({tag, "_date"},  date,      e.date);
        chk({tag, "_hour"},  hour,      e.hour);
        chk({tag, "_min"},   min,       e.min);
        chk({tag, "_sec"},   sec,       e.sec);
        chk({tag, "_day"},   day,       e.day);
        chk({tag, "_leap"},  leap_year, e.leap);
    endtask

    // Fixed observation window: busy cycles and new_day pulses are counted over 12 negedges
    task automatic do_tick(input string tag, input int exp_busy, input int exp_nd);
        int bcnt = 0;
        int ndcnt = 0;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (busy) bcnt++;
            if (new_day) ndcnt++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, bcnt, exp_busy);
        chk({tag, "_new_day"}, ndcnt, exp_nd);
    endtask

    task automatic do_load(input string tag, input logic [7:0] y, mo, d, h, mi, s,
                           input logic with_tick, input logic exp_err);
        int to = 0;
        while (!load_ready && to < 20) begin
            @(negedge clk);
            to++;
        end
        chk({tag, "_load_ready"}, load_ready, 1'b1);
        load_year = y; load_month = mo; load_date = d;
        load_hour = h; load_min = mi;   load_sec = s;
        load_valid = 1'b1;
        tick = with_tick;
        @(negedge clk);
        load_valid = 1'b0;
        tick = 1'b0;
        chk({tag, "_check_busy"}, busy, 1'b1);
        @(negedge clk);
        chk({tag, "_load_err"}, load_err, exp_err);
        @(negedge clk);
        chk({tag, "_load_err_clr"}, load_err, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; load_valid = 1'b0;
        load_sec = 8'h00; load_min = 8'h00; load_hour = 8'h00;
        load_date = 8'h00; load_month = 8'h00; load_year = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        push_exp(8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 3'd6, 1'b1);
        check_sb("reset");
        chk("reset_busy", busy, 1'b0);
        chk("reset_load_ready", load_ready, 1'b1);
        chk("reset_overrun", tick_overrun, 1'b0);
        chk("reset_new_day", new_day, 1'b0);
        chk("reset_load_err", load_err, 1'b0);

        // Three plain ticks
        for (int k = 1; k <= 3; k++) begin
            push_exp(8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'(k), 3'd6, 1'b1);
            do_tick("tick_plain", 1, 0);
            check_sb("tick_plain");
        end

        // Full century rollover
        push_exp(8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59, 3'd4, 1'b0);
        do_load("ld_99", 8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59, 1'b0, 1'b0);
        check_sb("ld_99");
        push_exp(8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 3'd6, 1'b1);
        do_tick("roll_99", 6, 1);
        check_sb("roll_99");

        // Leap February and ordinary February
        push_exp(8'h24, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59, 3'd3, 1'b1);
        do_load("ld_24", 8'h24, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59, 1'b0, 1'b0);
        check_sb("ld_24");
        push_exp(8'h24, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00, 3'd4, 1'b1);
        do_tick("feb_leap", 4, 1);
        check_sb("feb_leap");

        push_exp(8'h23, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59, 3'd2, 1'b0);
        do_load("ld_23", 8'h23, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59, 1'b0, 1'b0);
        check_sb("ld_23");
        push_exp(8'h23, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 3'd3, 1'b0);
        do_tick("feb_plain", 5, 1);
        check_sb("feb_plain");

        // Rejected loads leave the time untouched
        push_exp(8'h23, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 3'd3, 1'b0);
        do_load("ld_hour24", 8'h23, 8'h03, 8'h01, 8'h24, 8'h00, 8'h00, 1'b0, 1'b1);
        check_sb("ld_hour24");
        push_exp(8'h23, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 3'd3, 1'b0);
        do_load("ld_apr31", 8'h23, 8'h04, 8'h31, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        check_sb("ld_apr31");
        push_exp(8'h23, 8'h03, 8'h01, 8'h00, 8'h00, 8'h01, 3'd3, 1'b0);
        do_tick("after_rej", 1, 0);
        check_sb("after_rej");

        // Ticks while busy: one pending increment survives, the third tick is lost
        push_exp(8'h23, 8'h03, 8'h01, 8'h00, 8'h00, 8'h59, 3'd3, 1'b0);
        do_load("ld_ovr", 8'h23, 8'h03, 8'h01, 8'h00, 8'h00, 8'h59, 1'b0, 1'b0);
        check_sb("ld_ovr");
        tick = 1'b1;
        repeat (3) @(negedge clk);
        tick = 1'b0;
        repeat (10) @(negedge clk);
        push_exp(8'h23, 8'h03, 8'h01, 8'h00, 8'h01, 8'h01, 3'd3, 1'b0);
        check_sb("overrun");
        chk("overrun_flag", tick_overrun, 1'b1);
        chk("overrun_idle", busy, 1'b0);
        push_exp(8'h23, 8'h03, 8'h01, 8'h12, 8'h00, 8'h00, 3'd3, 1'b0);
        do_load("ld_clr", 8'h23, 8'h03, 8'h01, 8'h12, 8'h00, 8'h00, 1'b0, 1'b0);
        check_sb("ld_clr");
        chk("overrun_cleared", tick_overrun, 1'b0);

        // Tick and load in the same IDLE cycle: only the load takes effect
        push_exp(8'h23, 8'h03, 8'h01, 8'h10, 8'h20, 8'h30, 3'd3, 1'b0);
        do_load("ld_tick", 8'h23, 8'h03, 8'h01, 8'h10, 8'h20, 8'h30, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        chk("ld_tick_idle", busy, 1'b0);
        check_sb("ld_tick");

        // Reset asserted while the carry chain sits in DATE
        push_exp(8'h23, 8'h03, 8'h01, 8'h23, 8'h59, 8'h59, 3'd3, 1'b0);
        do_load("ld_rst", 8'h23, 8'h03, 8'h01, 8'h23, 8'h59, 8'h59, 1'b0, 1'b0);
        check_sb("ld_rst");
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (3) @(negedge clk);
        chk("date_state_busy", busy, 1'b1);
        chk("date_state_hour", hour, 8'h00);
        chk("date_state_date", date, 8'h01);
        rst_n = 1'b0;
        #1;
        push_exp(8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 3'd6, 1'b1);
        check_sb("mid_reset");
        chk("mid_reset_busy", busy, 1'b0);
        chk("mid_reset_overrun", tick_overrun, 1'b0);
        chk("mid_reset_new_day", new_day, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_busy", busy, 1'b0);
        chk("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
